// File: rtl/imm_gen_pkg.sv
// Shared definitions for the immediate generator stage.
//   imm_sel_e : format tag carried alongside every generated immediate.
//   OPC_*     : RV32/RV64 major opcodes recognised by the decoder.
//   F3_*      : funct3 values that turn OP-IMM / OP-IMM-32 into shift-amount forms.
package imm_gen_pkg;

   typedef enum logic [2:0] {
      SEL_NONE  = 3'd0,
      SEL_I     = 3'd1,
      SEL_S     = 3'd2,
      SEL_B     = 3'd3,
      SEL_U     = 3'd4,
      SEL_J     = 3'd5,
      SEL_SHAMT = 3'd6,
      SEL_ZIMM  = 3'd7
   } imm_sel_e;

   localparam logic [6:0] OPC_OP         = 7'b0110011;
   localparam logic [6:0] OPC_OP_32      = 7'b0111011;
   localparam logic [6:0] OPC_OP_IMM     = 7'b0010011;
   localparam logic [6:0] OPC_OP_IMM_32  = 7'b0011011;
   localparam logic [6:0] OPC_LOAD       = 7'b0000011;
   localparam logic [6:0] OPC_STORE      = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH     = 7'b1100011;
   localparam logic [6:0] OPC_LUI        = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC      = 7'b0010111;
   localparam logic [6:0] OPC_JAL        = 7'b1101111;
   localparam logic [6:0] OPC_JALR       = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM     = 7'b1110011;

   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SR  = 3'b101;

endpackage

// File: rtl/imm_gen_core.sv
// Combinational immediate extractor.
//   instr_i   [31:0]     raw instruction
//   imm_o     [XLEN-1:0] sign/zero-extended immediate (0 when the format has none)
//   sel_o     imm_sel_e  detected format
//   illegal_o            opcode outside the decoded set
module imm_gen_core
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     instr_i,
   output logic [XLEN-1:0] imm_o,
   output imm_sel_e        sel_o,
   output logic            illegal_o
);

   // Shift amounts are 5 bits on RV32 and 6 bits on RV64.
   localparam int SHAMT_W = $clog2(XLEN);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       is_shift;

   assign opcode   = instr_i[6:0];
   assign funct3   = instr_i[14:12];
   assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SR);

   always_comb begin
      imm_o     = '0;
      sel_o     = SEL_NONE;
      illegal_o = 1'b0;
      unique case (opcode)
         OPC_OP, OPC_OP_32: ;
         OPC_OP_IMM: begin
            if (is_shift) begin
               // instr[30] selects SRAI and must not leak into the amount.
               sel_o = SEL_SHAMT;
               imm_o = XLEN'(instr_i[20 +: SHAMT_W]);
            end else begin
               sel_o = SEL_I;
               imm_o = XLEN'($signed(instr_i[31:20]));
            end
         end
         OPC_OP_IMM_32: begin
            if (is_shift) begin
               // W-ops always shift by at most 31 regardless of XLEN.
               sel_o = SEL_SHAMT;
               imm_o = XLEN'(instr_i[24:20]);
            end else begin
               sel_o = SEL_I;
               imm_o = XLEN'($signed(instr_i[31:20]));
            end
         end
         OPC_LOAD, OPC_JALR: begin
            sel_o = SEL_I;
            imm_o = XLEN'($signed(instr_i[31:20]));
         end
         OPC_STORE: begin
            sel_o = SEL_S;
            imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
         end
         OPC_BRANCH: begin
            sel_o = SEL_B;
            imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                   instr_i[11:8], 1'b0}));
         end
         OPC_LUI, OPC_AUIPC: begin
            sel_o = SEL_U;
            imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
         end
         OPC_JAL: begin
            sel_o = SEL_J;
            imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                   instr_i[30:21], 1'b0}));
         end
         OPC_SYSTEM: begin
            // CSRR*I forms (funct3[2]=1) carry a 5-bit zero-extended uimm in rs1.
            if (funct3[2]) begin
               sel_o = SEL_ZIMM;
               imm_o = XLEN'(instr_i[19:15]);
            end else begin
               sel_o = SEL_I;
               imm_o = XLEN'($signed(instr_i[31:20]));
            end
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generator decode stage with a 2-entry (main + skid) buffer.
//   clk, rst (async, active-high), flush (sync kill of buffered entries)
//   in_valid/in_ready/in_instr/in_tag     : upstream handshake
//   out_valid/out_ready                   : downstream handshake
//   out_imm/out_sel/out_illegal/out_tag   : contents of the main register
// in_ready is taken straight from the skid-valid flop, so out_ready has no
// combinational path to it.
module imm_gen_stage
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_sel,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   logic [XLEN-1:0] core_imm;
   imm_sel_e        core_sel;
   logic            core_illegal;

   imm_gen_core #(.XLEN(XLEN)) u_core (
      .instr_i   (in_instr),
      .imm_o     (core_imm),
      .sel_o     (core_sel),
      .illegal_o (core_illegal)
   );

   logic             main_valid_q, main_valid_d;
   logic [XLEN-1:0]  main_imm_q,   main_imm_d;
   imm_sel_e         main_sel_q,   main_sel_d;
   logic             main_ill_q,   main_ill_d;
   logic [TAG_W-1:0] main_tag_q,   main_tag_d;

   logic             skid_valid_q, skid_valid_d;
   logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
   imm_sel_e         skid_sel_q,   skid_sel_d;
   logic             skid_ill_q,   skid_ill_d;
   logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

   logic accept;

   assign in_ready = ~skid_valid_q;
   assign accept   = in_valid & in_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      main_imm_d   = main_imm_q;
      main_sel_d   = main_sel_q;
      main_ill_d   = main_ill_q;
      main_tag_d   = main_tag_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_sel_d   = skid_sel_q;
      skid_ill_d   = skid_ill_q;
      skid_tag_d   = skid_tag_q;

      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || out_ready) begin
         // Main is free this edge; the skid (older) has priority. When the
         // skid is full in_ready is low, so no accept can collide with it.
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_imm_d   = skid_imm_q;
            main_sel_d   = skid_sel_q;
            main_ill_d   = skid_ill_q;
            main_tag_d   = skid_tag_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_valid_d = 1'b1;
            main_imm_d   = core_imm;
            main_sel_d   = core_sel;
            main_ill_d   = core_illegal;
            main_tag_d   = in_tag;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_imm_d   = core_imm;
         skid_sel_d   = core_sel;
         skid_ill_d   = core_illegal;
         skid_tag_d   = in_tag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_imm_q   <= '0;
         main_sel_q   <= SEL_NONE;
         main_ill_q   <= 1'b0;
         main_tag_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_imm_q   <= '0;
         skid_sel_q   <= SEL_NONE;
         skid_ill_q   <= 1'b0;
         skid_tag_q   <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_imm_q   <= main_imm_d;
         main_sel_q   <= main_sel_d;
         main_ill_q   <= main_ill_d;
         main_tag_q   <= main_tag_d;
         skid_valid_q <= skid_valid_d;
         skid_imm_q   <= skid_imm_d;
         skid_sel_q   <= skid_sel_d;
         skid_ill_q   <= skid_ill_d;
         skid_tag_q   <= skid_tag_d;
      end
   end

   assign out_valid   = main_valid_q;
   assign out_imm     = main_imm_q;
   assign out_sel     = main_sel_q;
   assign out_illegal = main_ill_q;
   assign out_tag     = main_tag_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: an XLEN=64 instance checked cycle by cycle against
// an occupancy/queue model, plus an XLEN=32 instance sharing the inputs.
module tb_imm_gen_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [7:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_imm;
   logic [2:0]  out_sel;
   logic        out_illegal;
   logic [7:0]  out_tag;

   logic        in_ready32;
   logic        out_valid32;
   logic        out_ready32 = 1'b1;
   logic [31:0] out_imm32;
   logic [2:0]  out_sel32;
   logic        out_illegal32;
   logic [7:0]  out_tag32;

   always #5 clk = ~clk;

   imm_gen_stage #(.XLEN(64), .TAG_W(8)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
      .out_sel(out_sel), .out_illegal(out_illegal), .out_tag(out_tag)
   );

   // Always-draining RV32 build fed with the same inputs.
   imm_gen_stage #(.XLEN(32), .TAG_W(8)) u_dut32 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(out_valid32), .out_ready(out_ready32), .out_imm(out_imm32),
      .out_sel(out_sel32), .out_illegal(out_illegal32), .out_tag(out_tag32)
   );

   typedef struct {
      logic [63:0] imm;
      logic [2:0]  sel;
      logic        ill;
      logic [7:0]  tag;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Two's-complement reinterpretation of an n-bit unsigned field.
   function automatic longint sx(input longint x, input int n);
      return (x >= (longint'(1) << (n - 1))) ? x - (longint'(1) << n) : x;
   endfunction

   function automatic exp_t ref_model(input logic [31:0] ins, input logic [7:0] tg, input int xlen);
      exp_t   e;
      longint v  = 0;
      int     op = int'(ins[6:0]);
      int     f3 = int'(ins[14:12]);
      bit     sh = (f3 == 1) || (f3 == 5);
      longint fi = sx(longint'(ins[31:20]), 12);
      e.ill = 1'b0;
      e.sel = 3'd0;
      e.tag = tg;
      if (op == 'h33 || op == 'h3B) begin
         v = 0;
      end else if (op == 'h13 && sh) begin
         e.sel = 3'd6; v = longint'(ins[25:20]) % xlen;
      end else if (op == 'h1B && sh) begin
         e.sel = 3'd6; v = longint'(ins[24:20]);
      end else if (op == 'h13 || op == 'h1B || op == 'h03 || op == 'h67) begin
         e.sel = 3'd1; v = fi;
      end else if (op == 'h23) begin
         e.sel = 3'd2; v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
      end else if (op == 'h63) begin
         e.sel = 3'd3;
         v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
      end else if (op == 'h37 || op == 'h17) begin
         e.sel = 3'd4; v = sx(longint'(ins[31:12]), 20) * 4096;
      end else if (op == 'h6F) begin
         e.sel = 3'd5;
         v = sx(longint'(ins[31]) * (1 << 20) + longint'(ins[19:12]) * 4096 +
                longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
      end else if (op == 'h73) begin
         if (f3 >= 4) begin e.sel = 3'd7; v = longint'(ins[19:15]); end
         else begin e.sel = 3'd1; v = fi; end
      end else begin
         e.ill = 1'b1; v = 0;
      end
      e.imm = (xlen == 32) ? {32'h0, v[31:0]} : v;
      return e;
   endfunction

   task automatic check_outputs();
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, q.size() < 2);
      if (q.size() > 0) begin
         chk("out_imm", out_imm, q[0].imm);
         chk("out_sel", out_sel, q[0].sel);
         chk("out_illegal", out_illegal, q[0].ill);
         chk("out_tag", out_tag, q[0].tag);
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, check #1 later.
   task automatic step(input bit iv, input logic [31:0] ins, input logic [7:0] tg,
                       input bit ordy, input bit fl, output bit acc);
      bit deq;
      in_valid  = iv;
      in_instr  = ins;
      in_tag    = tg;
      out_ready = ordy;
      flush     = fl;
      acc = iv && (q.size() < 2);
      deq = (q.size() > 0) && ordy;
      @(posedge clk);
      if (fl) begin
         q.delete();
         acc = 1'b0;
      end else begin
         if (deq) void'(q.pop_front());
         if (acc) q.push_back(ref_model(ins, tg, 64));
      end
      #1;
      check_outputs();
   endtask

   logic [31:0] dv_instr [8] = '{32'hFFF00093, 32'h800000B7, 32'h03F09093, 32'h4030D093,
                                 32'hFFDFF06F, 32'h300FD073, 32'h0000007F, 32'h01F09093};
   logic [63:0] dv_imm   [8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'd63, 64'd3,
                                 64'hFFFF_FFFF_FFFF_FFFC, 64'd31, 64'd0, 64'd31};
   logic [2:0]  dv_sel   [8] = '{3'd1, 3'd4, 3'd6, 3'd6, 3'd5, 3'd7, 3'd0, 3'd6};
   logic        dv_ill   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [6:0]  opc_pool [15] = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h23, 7'h63,
                                  7'h37, 7'h17, 7'h6F, 7'h73, 7'h7F, 7'h0F, 7'h13};

   initial begin
      bit          a;
      exp_t        e32;
      logic [31:0] stream [4];
      int          idx;
      int          cyc;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset out_valid", out_valid, 1'b0);
      chk("reset in_ready", in_ready, 1'b1);
      chk("reset out_imm", out_imm, 64'h0);
      chk("reset out_sel", out_sel, 3'd0);
      chk("reset out_illegal", out_illegal, 1'b0);
      chk("reset out_tag", out_tag, 8'h0);
      chk("reset out_valid32", out_valid32, 1'b0);

      // Directed vectors, one per cycle with the consumer always ready.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, dv_instr[i], 8'(i + 1), 1'b1, 1'b0, a);
         chk("vec imm", out_imm, dv_imm[i]);
         chk("vec sel", out_sel, dv_sel[i]);
         chk("vec illegal", out_illegal, dv_ill[i]);
         e32 = ref_model(dv_instr[i], 8'(i + 1), 32);
         chk("vec32 valid", out_valid32, 1'b1);
         chk("vec32 imm", out_imm32, e32.imm[31:0]);
         chk("vec32 sel", out_sel32, e32.sel);
      end
      chk("rv32 slli31", out_imm32, 32'd31);
      step(1'b1, 32'h800000B7, 8'h55, 1'b1, 1'b0, a);
      chk("rv32 lui", out_imm32, 32'h8000_0000);
      step(1'b0, '0, '0, 1'b1, 1'b0, a);

      // Four instructions offered with out_ready low, then released.
      stream = '{32'h00500093, 32'hFE000EE3, 32'h00112623, 32'h12345037};
      idx = 0;
      cyc = 0;
      while (idx < 4 && cyc < 40) begin
         step(1'b1, stream[idx], 8'(8'hA0 + idx), cyc >= 4, 1'b0, a);
         if (cyc == 1) chk("in_ready low after skid fill", in_ready, 1'b0);
         if (a) idx++;
         cyc++;
      end
      chk("stream all accepted", idx, 4);
      for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0, a);
      chk("stream drained", out_valid, 1'b0);

      // Fill main + skid, then flush with a valid input present.
      step(1'b1, 32'h00A00093, 8'hB0, 1'b0, 1'b0, a);
      step(1'b1, 32'h00B00093, 8'hB1, 1'b0, 1'b0, a);
      chk("skid full", in_ready, 1'b0);
      step(1'b1, 32'h00C00093, 8'hB2, 1'b0, 1'b1, a);
      chk("flush out_valid", out_valid, 1'b0);
      chk("flush in_ready", in_ready, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0, a);

      // Randomised traffic with occasional flush.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] r;
         r = $urandom;
         r[6:0] = opc_pool[$urandom_range(0, 14)];
         step($urandom_range(0, 3) != 0, r, 8'($urandom), $urandom_range(0, 2) != 0,
              $urandom_range(0, 39) == 0, a);
      end

      // Asynchronous reset mid-stream.
      step(1'b1, 32'h00700093, 8'hC0, 1'b0, 1'b0, a);
      step(1'b1, 32'h00800093, 8'hC1, 1'b0, 1'b0, a);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst out_valid", out_valid, 1'b0);
      chk("async rst out_imm", out_imm, 64'h0);
      chk("async rst out_sel", out_sel, 3'd0);
      chk("async rst out_tag", out_tag, 8'h0);
      chk("async rst in_ready", in_ready, 1'b1);
      q.delete();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b1, 32'hFFF00093, 8'hD0, 1'b1, 1'b0, a);
      chk("post-reset imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("post-reset tag", out_tag, 8'hD0);
      step(1'b0, '0, '0, 1'b1, 1'b0, a);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
